// File: rtl/overcurrent_supervisor.sv
// Overcurrent supervisor: trip -> cooldown -> auto-restart, lockout after too many retries.
// Optional lifetime trip counter enabled by macro OVERCURRENT_TRIP_COUNT_EN.
module overcurrent_supervisor #(
   parameter int unsigned COOLDOWN_CYCLES = 50000,
   parameter int unsigned GOOD_CYCLES     = 250000,
   parameter int unsigned MAX_RETRIES     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_req,
   input  logic        current_high,
   input  logic        fault_clr,
   output logic        power_en,
   output logic        fault,
   output logic        lockout,
   output logic [3:0]  retry_cnt,
   output logic [1:0]  state,
   output logic [15:0] trip_count
);

   localparam int unsigned CNT_MAX = (COOLDOWN_CYCLES > GOOD_CYCLES) ? COOLDOWN_CYCLES : GOOD_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam logic [4:0]  MAX_R   = 5'(MAX_RETRIES);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_COOLDOWN = 2'd2,
      ST_LOCKOUT  = 2'd3
   } state_t;

   state_t         r_state, w_next;
   logic [CW-1:0]  r_cnt, w_cnt_next;
   logic [3:0]     r_retry, w_retry_next;
   logic [4:0]     w_retry_inc;
   logic           r_power_en, r_fault, r_lockout;

   // One counter serves both phases: cooldown length in COOLDOWN, trip-free run length in RUN
   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt;
      w_retry_next = r_retry;
      w_retry_inc  = {1'b0, r_retry} + 5'd1;
      case (r_state)
         ST_IDLE: begin
            if (enable_req) begin
               w_next     = ST_RUN;
               w_cnt_next = '0;
            end
         end
         ST_RUN: begin
            if (current_high) begin
               w_cnt_next   = '0;
               w_retry_next = (w_retry_inc > 5'd15) ? 4'hF : w_retry_inc[3:0];
               w_next       = (w_retry_inc > MAX_R) ? ST_LOCKOUT : ST_COOLDOWN;
            end else begin
               if (!enable_req) w_next = ST_IDLE;
               if (r_cnt < CW'(GOOD_CYCLES)) begin
                  w_cnt_next = r_cnt + CW'(1);
                  if (r_cnt == CW'(GOOD_CYCLES - 1)) w_retry_next = '0;
               end
            end
         end
         ST_COOLDOWN: begin
            if (r_cnt == CW'(COOLDOWN_CYCLES - 1)) begin
               w_next     = enable_req ? ST_RUN : ST_IDLE;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         ST_LOCKOUT: begin
            if (fault_clr && !enable_req) begin
               w_next       = ST_IDLE;
               w_retry_next = '0;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_retry    <= '0;
         r_power_en <= 1'b0;
         r_fault    <= 1'b0;
         r_lockout  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_cnt      <= w_cnt_next;
         r_retry    <= w_retry_next;
         r_power_en <= (w_next == ST_RUN);
         r_fault    <= (w_next == ST_COOLDOWN) || (w_next == ST_LOCKOUT);
         r_lockout  <= (w_next == ST_LOCKOUT);
      end
   end

   assign power_en  = r_power_en;
   assign fault     = r_fault;
   assign lockout   = r_lockout;
   assign retry_cnt = r_retry;
   assign state     = r_state;

`ifdef OVERCURRENT_TRIP_COUNT_EN
   logic        w_trip;
   logic [15:0] r_trip_cnt;

   assign w_trip = (r_state == ST_RUN) && current_high;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_trip_cnt <= '0;
      else if (w_trip && (r_trip_cnt != 16'hFFFF))
         r_trip_cnt <= r_trip_cnt + 16'd1;
   end

   assign trip_count = r_trip_cnt;
`else
   assign trip_count = '0;
`endif

endmodule

// File: tb/tb_overcurrent_supervisor.sv
// Directed self-checking bench for overcurrent_supervisor (COOLDOWN=10, GOOD=20, MAX_RETRIES=2).
module tb_overcurrent_supervisor;

   logic        clk = 1'b0;
   logic        rst_n, enable_req, current_high, fault_clr;
   logic        power_en, fault, lockout;
   logic [3:0]  retry_cnt;
   logic [1:0]  state;
   logic [15:0] trip_count;

   int errors = 0;
   int checks = 0;

   overcurrent_supervisor #(
      .COOLDOWN_CYCLES(10),
      .GOOD_CYCLES    (20),
      .MAX_RETRIES    (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_req  (enable_req),
      .current_high(current_high),
      .fault_clr   (fault_clr),
      .power_en    (power_en),
      .fault       (fault),
      .lockout     (lockout),
      .retry_cnt   (retry_cnt),
      .state       (state),
      .trip_count  (trip_count)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable_req = 1'b0; current_high = 1'b0; fault_clr = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (state !== 2'd0)      begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (power_en !== 1'b0)   begin errors++; $display("FAIL reset_power_en: got %b want 0", power_en); end
      checks++; if (fault !== 1'b0)      begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
      checks++; if (lockout !== 1'b0)    begin errors++; $display("FAIL reset_lockout: got %b want 0", lockout); end
      checks++; if (retry_cnt !== 4'd0)  begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
      checks++; if (trip_count !== 16'd0) begin errors++; $display("FAIL reset_trip_count: got %0d want 0", trip_count); end
   endtask

   task automatic test_enable();
      tick(3);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", state); end
      enable_req = 1'b1;
      tick(1);
      checks++; if (state !== 2'd1)    begin errors++; $display("FAIL enable_state: got %0d want 1", state); end
      checks++; if (power_en !== 1'b1) begin errors++; $display("FAIL enable_power_en: got %b want 1", power_en); end
   endtask

   task automatic test_single_trip();
      current_high = 1'b1;
      tick(1);
      current_high = 1'b0;
      checks++; if (power_en !== 1'b0)  begin errors++; $display("FAIL trip_power_en: got %b want 0", power_en); end
      checks++; if (state !== 2'd2)     begin errors++; $display("FAIL trip_state: got %0d want 2", state); end
      checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL trip_retry: got %0d want 1", retry_cnt); end
      // current_high held during part of cooldown must be ignored
      for (int i = 1; i < 10; i++) begin
         current_high = (i >= 3 && i <= 6);
         tick(1);
         checks++;
         if (fault !== 1'b1 || state !== 2'd2)
            begin errors++; $display("FAIL cooldown_cycle%0d: got fault=%b state=%0d want fault=1 state=2", i, fault, state); end
      end
      current_high = 1'b0;
      tick(1);
      checks++; if (state !== 2'd1 || power_en !== 1'b1 || fault !== 1'b0)
         begin errors++; $display("FAIL cooldown_exit: got state=%0d pe=%b fault=%b want 1 1 0", state, power_en, fault); end
      checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL cooldown_retry_kept: got %0d want 1", retry_cnt); end
   endtask

   task automatic test_lockout();
      do_reset();
      enable_req = 1'b1;
      tick(1);
      for (int t = 1; t <= 2; t++) begin
         tick(3);
         current_high = 1'b1; tick(1); current_high = 1'b0;
         tick(10);
      end
      checks++; if (state !== 2'd1 || retry_cnt !== 4'd2)
         begin errors++; $display("FAIL pre_lockout: got state=%0d retry=%0d want 1 2", state, retry_cnt); end
      current_high = 1'b1; tick(1); current_high = 1'b0;
      checks++; if (state !== 2'd3)     begin errors++; $display("FAIL lockout_state: got %0d want 3", state); end
      checks++; if (lockout !== 1'b1 || fault !== 1'b1 || power_en !== 1'b0)
         begin errors++; $display("FAIL lockout_flags: got lo=%b fault=%b pe=%b want 1 1 0", lockout, fault, power_en); end
      checks++; if (retry_cnt !== 4'd3) begin errors++; $display("FAIL lockout_retry: got %0d want 3", retry_cnt); end
      tick(15);
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL lockout_sticky: got %0d want 3", state); end
   endtask

   task automatic test_fault_clr();
      fault_clr = 1'b1; enable_req = 1'b1;
      tick(3);
      checks++; if (state !== 2'd3 || lockout !== 1'b1)
         begin errors++; $display("FAIL clr_with_enable: got state=%0d lo=%b want 3 1", state, lockout); end
      enable_req = 1'b0;
      tick(1);
      fault_clr = 1'b0;
      checks++; if (state !== 2'd0 || retry_cnt !== 4'd0)
         begin errors++; $display("FAIL clr_exit: got state=%0d retry=%0d want 0 0", state, retry_cnt); end
      checks++; if (fault !== 1'b0 || lockout !== 1'b0)
         begin errors++; $display("FAIL clr_flags: got fault=%b lo=%b want 0 0", fault, lockout); end
   endtask

   task automatic test_good_clear();
      do_reset();
      enable_req = 1'b1;
      tick(1);
      current_high = 1'b1; tick(1); current_high = 1'b0;
      tick(10);
      // fault_clr outside lockout must not touch the retry count
      fault_clr = 1'b1;
      tick(19);
      fault_clr = 1'b0;
      checks++; if (retry_cnt !== 4'd1) begin errors++; $display("FAIL good_19: got %0d want 1", retry_cnt); end
      tick(1);
      checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL good_20: got %0d want 0", retry_cnt); end
      tick(5);
      current_high = 1'b1; enable_req = 1'b0;
      tick(1);
      current_high = 1'b0;
      checks++; if (state !== 2'd2 || retry_cnt !== 4'd1)
         begin errors++; $display("FAIL trip_priority: got state=%0d retry=%0d want 2 1", state, retry_cnt); end
      tick(10);
      checks++; if (state !== 2'd0 || power_en !== 1'b0 || fault !== 1'b0)
         begin errors++; $display("FAIL cooldown_to_idle: got state=%0d pe=%b fault=%b want 0 0 0", state, power_en, fault); end
   endtask

   task automatic test_reset_mid_cooldown();
      logic [15:0] exp_trips;
`ifdef OVERCURRENT_TRIP_COUNT_EN
      exp_trips = 16'd3;
`else
      exp_trips = 16'd0;
`endif
      do_reset();
      enable_req = 1'b1;
      tick(1);
      current_high = 1'b1; tick(1); current_high = 1'b0;
      tick(4);
      rst_n = 1'b0;
      tick(1);
      checks++; if (state !== 2'd0 || power_en !== 1'b0 || fault !== 1'b0 || lockout !== 1'b0 || retry_cnt !== 4'd0 || trip_count !== 16'd0)
         begin errors++; $display("FAIL reset_mid_cooldown: got st=%0d pe=%b f=%b lo=%b rc=%0d tc=%0d want all 0", state, power_en, fault, lockout, retry_cnt, trip_count); end
      rst_n = 1'b1;
      tick(1);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL restart_after_reset: got %0d want 1", state); end
      for (int t = 0; t < 2; t++) begin
         current_high = 1'b1; tick(1); current_high = 1'b0;
         tick(10);
      end
      current_high = 1'b1; tick(1); current_high = 1'b0;
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL third_trip_state: got %0d want 3", state); end
      checks++; if (trip_count !== exp_trips) begin errors++; $display("FAIL trip_count: got %0d want %0d", trip_count, exp_trips); end
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1; enable_req = 1'b0;
      checks++; if (state !== 2'd0 || lockout !== 1'b0 || retry_cnt !== 4'd0 || trip_count !== 16'd0)
         begin errors++; $display("FAIL reset_in_lockout: got st=%0d lo=%b rc=%0d tc=%0d want 0 0 0 0", state, lockout, retry_cnt, trip_count); end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_single_trip();
      test_lockout();
      test_fault_clr();
      test_good_clear();
      test_reset_mid_cooldown();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
